uart_mmio: RTL and testbench

Memory-mapped I/O controller between the Riscv151 datapath's load/store path and the on-chip `uart`. It decodes CPU accesses in the 0x8000_00xx I/O space, holds one outgoing byte toward the UART transmitter and buffers received bytes in a small FIFO. It also keeps the cycle and retired-instruction counters that software reads for benchmarking.

---
 rtl/riscv_io_pkg.sv | 15 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_mmio.sv | 123 ++++++++++++
 tb/tb_uart_mmio.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_io_pkg.sv
// Shared I/O-space constants for the Riscv151 memory-mapped peripherals.
// IO_BASE_NIBBLE selects the I/O region through io_addr[31:28]. The offsets
// are decoded from io_addr[7:0].
package riscv_io_pkg;

    localparam logic [3:0] IO_BASE_NIBBLE = 4'h8;

    localparam logic [7:0] IO_UART_CTRL = 8'h00;
    localparam logic [7:0] IO_UART_RX   = 8'h04;
    localparam logic [7:0] IO_UART_TX   = 8'h08;
    localparam logic [7:0] IO_CYCLE_CNT = 8'h10;
    localparam logic [7:0] IO_INST_CNT  = 8'h14;
    localparam logic [7:0] IO_CNT_RST   = 8'h18;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy count.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data - write request and data; ignored while full
//   pop, pop_data   - read request and head entry; pop ignored while empty
//   full, empty     - occupancy flags
// DEPTH must be a power of two (at least 2) so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = count_q == CNT_W'(DEPTH);
    assign empty   = count_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_data = mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            // Simultaneous push and pop leaves the count unchanged.
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

    // Storage needs no reset: the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART and benchmark-counter block for the Riscv151 I/O space.
// Ports:
//   clk, rst                    - clock, asynchronous active-low reset
//   io_addr/io_re/io_we/io_wdata - CPU load/store access, selected by addr[31:28]
//   io_rdata                    - registered load data (1-cycle latency)
//   inst_retire                 - one instruction retired this cycle
//   uart_tx_data/valid/ready    - one-byte holding register toward the UART TX
//   uart_rx_data/valid/ready    - received bytes into the RX FIFO
module uart_mmio
    import riscv_io_pkg::*;
#(
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_addr,
    input  logic        io_re,
    input  logic        io_we,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic        inst_retire,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    logic       sel, rd, wr;
    logic [7:0] off;
    logic       tx_full_q;
    logic [7:0] tx_data_q;
    logic       tx_load, tx_fire;
    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_head;
    logic [31:0] cycle_q, inst_q;
    logic       cnt_clr;
    logic [31:0] rdata_d;
    logic       unused_bits;

    assign sel = io_addr[31:28] == IO_BASE_NIBBLE;
    assign rd  = sel && io_re;
    assign wr  = sel && io_we;
    assign off = io_addr[7:0];

    assign unused_bits = ^{io_addr[27:8], io_wdata[31:8]};

    // TX holding register. A store arriving while full (including the
    // handshake cycle) is dropped, so load and fire never coincide.
    assign tx_load       = wr && (off == IO_UART_TX) && !tx_full_q;
    assign tx_fire       = tx_full_q && uart_tx_ready;
    assign uart_tx_valid = tx_full_q;
    assign uart_tx_data  = tx_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_full_q <= 1'b0;
            tx_data_q <= 8'h00;
        end else if (tx_load) begin
            tx_full_q <= 1'b1;
            tx_data_q <= io_wdata[7:0];
        end else if (tx_fire) begin
            tx_full_q <= 1'b0;
        end
    end

    // RX FIFO
    assign uart_rx_ready = !fifo_full;
    assign fifo_push     = uart_rx_valid && !fifo_full;
    assign fifo_pop      = rd && (off == IO_UART_RX) && !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (uart_rx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Benchmark counters; a clear store beats a same-cycle increment.
    assign cnt_clr = wr && (off == IO_CNT_RST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q <= 32'd0;
            inst_q  <= 32'd0;
        end else if (cnt_clr) begin
            cycle_q <= 32'd0;
            inst_q  <= 32'd0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            inst_q  <= inst_q + {31'd0, inst_retire};
        end
    end

    // Read mux sees pre-update state of the load cycle.
    always_comb begin
        rdata_d = 32'd0;
        case (off)
            IO_UART_CTRL: rdata_d = {30'd0, !fifo_empty, !tx_full_q};
            IO_UART_RX:   rdata_d = fifo_empty ? 32'd0 : {24'd0, fifo_head};
            IO_CYCLE_CNT: rdata_d = cycle_q;
            IO_INST_CNT:  rdata_d = inst_q;
            default:      rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_rdata <= 32'd0;
        end else if (rd) begin
            io_rdata <= rdata_d;
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
module tb_uart_mmio;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] io_addr, io_wdata, io_rdata;
    logic        io_re, io_we, inst_retire;
    logic [7:0]  uart_tx_data, uart_rx_data;
    logic        uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_ready;

    always #5 clk = ~clk;

    uart_mmio #(.RX_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .io_addr       (io_addr),
        .io_re         (io_re),
        .io_we         (io_we),
        .io_wdata      (io_wdata),
        .io_rdata      (io_rdata),
        .inst_retire   (inst_retire),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: expected load results and expected transmitted bytes.
    logic [31:0] exp_q[$];
    logic [7:0]  tx_q[$];

    // Reference model state.
    logic [7:0]  m_rx[$];
    bit          m_tx_full;
    logic [7:0]  m_tx_byte;
    logic [31:0] m_cyc, m_inst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rx.delete();
        m_tx_full = 0;
        m_tx_byte = 8'h00;
        m_cyc     = 32'd0;
        m_inst    = 32'd0;
        exp_q.delete();
        tx_q.delete();
    endtask

    // Inputs for this cycle are already driven: check outputs, predict, advance.
    task automatic step();
        bit         sel, rd, wr, pop, push_ok, accept;
        logic [7:0] off;
        sel = (io_addr[31:28] == 4'h8);
        rd  = sel && io_re;
        wr  = sel && io_we;
        off = io_addr[7:0];
        check("tx_valid", {31'd0, uart_tx_valid}, {31'd0, m_tx_full});
        check("rx_ready", {31'd0, uart_rx_ready}, (m_rx.size() < DEPTH) ? 32'd1 : 32'd0);
        if (m_tx_full) check("tx_data", {24'd0, uart_tx_data}, {24'd0, m_tx_byte});
        pop = 0;
        if (rd) begin
            case (off)
                8'h00: exp_q.push_back({30'd0, m_rx.size() != 0, !m_tx_full});
                8'h04: begin
                    if (m_rx.size() != 0) begin
                        exp_q.push_back({24'd0, m_rx[0]});
                        pop = 1;
                    end else begin
                        exp_q.push_back(32'd0);
                    end
                end
                8'h10:   exp_q.push_back(m_cyc);
                8'h14:   exp_q.push_back(m_inst);
                default: exp_q.push_back(32'd0);
            endcase
        end
        push_ok = uart_rx_valid && (m_rx.size() < DEPTH);
        if (pop) void'(m_rx.pop_front());
        if (push_ok) m_rx.push_back(uart_rx_data);
        accept = wr && (off == 8'h08) && !m_tx_full;
        if (m_tx_full && uart_tx_ready) m_tx_full = 0;
        if (accept) begin
            m_tx_full = 1;
            m_tx_byte = io_wdata[7:0];
            tx_q.push_back(io_wdata[7:0]);
        end
        if (wr && off == 8'h18) begin
            m_cyc  = 32'd0;
            m_inst = 32'd0;
        end else begin
            m_cyc  = m_cyc + 32'd1;
            m_inst = m_inst + {31'd0, inst_retire};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        io_re = 0; io_we = 0; uart_rx_valid = 0; inst_retire = 0;
    endtask

    task automatic load(input logic [7:0] off);
        io_re = 1; io_addr = {4'h8, 20'h0, off};
        step();
        io_re = 0;
    endtask

    task automatic store(input logic [7:0] off, input logic [31:0] data);
        io_we = 1; io_addr = {4'h8, 20'h0, off}; io_wdata = data;
        step();
        io_we = 0;
    endtask

    task automatic push_rx(input logic [7:0] b);
        uart_rx_valid = 1; uart_rx_data = b;
        step();
        uart_rx_valid = 0;
    endtask

    // Monitor: compares registered load data and TX handshakes.
    bit ld_pend = 0;
    always @(negedge clk) begin
        if (ld_pend) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rdata: got %h with no load expected", io_rdata);
            end else begin
                check("rdata", io_rdata, exp_q.pop_front());
            end
        end
        if (uart_tx_valid && uart_tx_ready) begin
            if (tx_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL tx_send: byte %h sent, none expected", uart_tx_data);
            end else begin
                check("tx_send", {24'd0, uart_tx_data}, {24'd0, tx_q.pop_front()});
            end
        end
        ld_pend = rst && io_re && (io_addr[31:28] == 4'h8);
    end

    logic [7:0] offs [8] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0c, 8'h1c};

    initial begin
        rst = 0; idle();
        io_addr = 32'd0; io_wdata = 32'd0; uart_tx_ready = 1; uart_rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset rdata", io_rdata, 32'd0);
        check("reset tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        check("reset tx_data", {24'd0, uart_tx_data}, 32'd0);
        check("reset rx_ready", {31'd0, uart_rx_ready}, 32'd1);
        rst = 1;
        model_reset();
        load(8'h00);

        // TX backpressure with a dropped second store
        uart_tx_ready = 0;
        store(8'h08, 32'h0000_0041);
        step(); step();
        store(8'h08, 32'h0000_0042);
        step(); step();
        check("tx hold data", {24'd0, uart_tx_data}, 32'h41);
        uart_tx_ready = 1;
        step();
        check("tx valid drop", {31'd0, uart_tx_valid}, 32'd0);
        load(8'h00);
        step();

        // RX fill, drain, over-read
        push_rx(8'h11); push_rx(8'h22); push_rx(8'h33); push_rx(8'h44);
        check("rx full ready", {31'd0, uart_rx_ready}, 32'd0);
        repeat (5) load(8'h04);
        load(8'h00);

        // Simultaneous push and pop with two entries
        push_rx(8'h61); push_rx(8'h62);
        uart_rx_valid = 1; uart_rx_data = 8'h63;
        load(8'h04);
        uart_rx_valid = 0;
        load(8'h00);
        repeat (3) load(8'h04);

        // Counters
        for (int i = 0; i < 100; i++) begin
            inst_retire = (i % 2) != 0;
            step();
        end
        inst_retire = 0;
        load(8'h10);
        load(8'h14);
        inst_retire = 1;
        store(8'h18, 32'd0);
        inst_retire = 0;
        load(8'h10);
        inst_retire = 1;
        load(8'h14);
        inst_retire = 0;
        load(8'h14);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            io_addr       = $urandom;
            io_addr[7:0]  = offs[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) < 8) io_addr[31:28] = 4'h8;
            io_re         = $urandom_range(0, 2) == 0;
            io_we         = $urandom_range(0, 3) == 0;
            io_wdata      = $urandom;
            inst_retire   = $urandom_range(0, 1) != 0;
            uart_rx_valid = $urandom_range(0, 1) != 0;
            uart_rx_data  = 8'($urandom);
            uart_tx_ready = $urandom_range(0, 2) != 0;
            step();
        end
        idle();
        uart_tx_ready = 1;
        repeat (2) step();
        repeat (DEPTH) load(8'h04);

        // Mid-operation reset with pending TX and 3 RX entries
        uart_tx_ready = 0;
        store(8'h08, 32'h0000_0077);
        push_rx(8'ha1); push_rx(8'ha2); push_rx(8'ha3);
        step();
        rst = 0;
        #1;
        check("async tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        check("async rx_ready", {31'd0, uart_rx_ready}, 32'd1);
        check("async rdata", io_rdata, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        uart_tx_ready = 1;
        step();
        load(8'h00);
        load(8'h04);
        load(8'h10);
        repeat (3) step();

        check("scoreboard drained", exp_q.size(), 32'd0);
        check("tx queue drained", tx_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
